// File: rtl/alu_pkg.sv
// Shared width and opcode encodings for the 4-bit ALU datapath.
// Imported by the top level and the divider.
package alu_pkg;

  localparam int W = 4;

  localparam logic [2:0] OC_ADD = 3'b000;
  localparam logic [2:0] OC_SUB = 3'b001;
  localparam logic [2:0] OC_MUL = 3'b010;
  localparam logic [2:0] OC_DIV = 3'b011;
  localparam logic [2:0] OC_NOT = 3'b100;
  localparam logic [2:0] OC_XOR = 3'b101;
  localparam logic [2:0] OC_OR  = 3'b110;
  localparam logic [2:0] OC_AND = 3'b111;

endpackage

// File: rtl/alu_div4.sv
// Combinational restoring divider: unsigned quotient of a/b.
// A zero divisor yields an all-ones quotient and raises div_zero_o.
module alu_div4
  import alu_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] quo_o,
  output logic         div_zero_o
);

  logic [W:0]   trial;
  logic [W-1:0] rem;
  logic [W-1:0] quo;

  always_comb begin
    rem   = '0;
    quo   = '0;
    trial = '0;
    // One quotient bit per step, MSB first; remainder is always < b so it fits in W bits.
    for (int i = W - 1; i >= 0; i--) begin
      trial = {rem, a_i[i]};
      if (trial >= {1'b0, b_i}) begin
        rem    = W'(trial - {1'b0, b_i});
        quo[i] = 1'b1;
      end else begin
        rem = trial[W-1:0];
      end
    end
    if (b_i == '0) begin
      quo = '1;
    end
  end

  assign quo_o      = quo;
  assign div_zero_o = (b_i == '0);

endmodule

// File: rtl/alu_4bit.sv
// 4-bit, 8-operation ALU: opcode mux and flag logic feeding one register
// stage that holds the result f and the z/c/dz status flags.
module alu_4bit
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   oc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] f,
  output logic         z,
  output logic         c,
  output logic         dz
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic           div_zero;

  logic [W-1:0]   f_d, f_q;
  logic           z_d, z_q;
  logic           c_d, c_q;
  logic           dz_d, dz_q;

  alu_div4 u_div (
    .a_i        (a),
    .b_i        (b),
    .quo_o      (quo),
    .div_zero_o (div_zero)
  );

  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  always_comb begin
    f_d  = '0;
    c_d  = 1'b0;
    dz_d = 1'b0;
    case (oc)
      // The extra top bit of the widened sum/difference is the carry/borrow.
      OC_ADD: {c_d, f_d} = {1'b0, a} + {1'b0, b};
      OC_SUB: {c_d, f_d} = {1'b0, a} - {1'b0, b};
      OC_MUL: begin
        f_d = prod[W-1:0];
        c_d = |prod[2*W-1:W];
      end
      OC_DIV: begin
        f_d  = quo;
        dz_d = div_zero;
      end
      OC_NOT: f_d = ~a;
      OC_XOR: f_d = a ^ b;
      OC_OR:  f_d = a | b;
      OC_AND: f_d = a & b;
      default: f_d = '0;
    endcase
    z_d = (f_d == '0);
  end

  // ---- result register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q  <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      f_q  <= f_d;
      z_q  <= z_d;
      c_q  <= c_d;
      dz_q <= dz_d;
    end
  end

  assign f  = f_q;
  assign z  = z_q;
  assign c  = c_q;
  assign dz = dz_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: reset behaviour, exhaustive sweep,
// directed edge vectors and a randomized back-to-back stream.
module tb_alu_4bit;

  logic       clk;
  logic       rst;
  logic [2:0] oc;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] f;
  logic       z;
  logic       c;
  logic       dz;

  int checks;
  int failures;

  typedef struct {
    logic [2:0] oc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] f;
    logic       z;
    logic       c;
    logic       dz;
  } vec_t;

  vec_t vecs [0:10];

  alu_4bit dut (
    .clk (clk),
    .rst (rst),
    .oc  (oc),
    .a   (a),
    .b   (b),
    .f   (f),
    .z   (z),
    .c   (c),
    .dz  (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic; returns {f,z,c,dz}.
  function automatic logic [6:0] model(input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv);
    int ai, bi, r;
    logic [3:0] rf;
    logic rc, rdz;
    ai = int'(av);
    bi = int'(bv);
    rc = 1'b0;
    rdz = 1'b0;
    rf = 4'd0;
    case (op)
      3'd0: begin r = ai + bi; rf = 4'(r % 16); rc = (r > 15); end
      3'd1: begin r = ai - bi + 16; rf = 4'(r % 16); rc = (ai < bi); end
      3'd2: begin r = ai * bi; rf = 4'(r % 16); rc = (r >= 16); end
      3'd3: begin
        if (bi == 0) begin rf = 4'd15; rdz = 1'b1; end
        else rf = 4'(ai / bi);
      end
      3'd4: rf = 4'(15 - ai);
      3'd5: rf = av ^ bv;
      3'd6: rf = av | bv;
      default: rf = av & bv;
    endcase
    return {rf, (rf == 4'd0), rc, rdz};
  endfunction

  task automatic test_reset();
    rst = 1'b1; oc = 3'd0; a = 4'd0; b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({f, z, c, dz} !== 7'b0) begin
      failures++;
      $display("FAIL reset_initial got=%b want=%b", {f, z, c, dz}, 7'b0);
    end
    @(negedge clk);
    rst = 1'b0; oc = 3'd3; a = 4'd7; b = 4'd0;
    @(posedge clk); #1;
    checks++;
    if ({f, z, c, dz} !== 7'b1111_0_0_1) begin
      failures++;
      $display("FAIL reset_pre_divzero got=%b want=%b", {f, z, c, dz}, 7'b1111001);
    end
    // Mid-cycle asynchronous assertion must clear outputs before the next edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({f, z, c, dz} !== 7'b0) begin
      failures++;
      $display("FAIL reset_async got=%b want=%b", {f, z, c, dz}, 7'b0);
    end
    @(posedge clk); #1;
    checks++;
    if ({f, z, c, dz} !== 7'b0) begin
      failures++;
      $display("FAIL reset_held got=%b want=%b", {f, z, c, dz}, 7'b0);
    end
    @(negedge clk);
    rst = 1'b0; oc = 3'd0; a = 4'hF; b = 4'h1;
    #1;
    checks++;
    if ({f, z, c, dz} !== 7'b0) begin
      failures++;
      $display("FAIL reset_release_nocapture got=%b want=%b", {f, z, c, dz}, 7'b0);
    end
    @(posedge clk); #1;
    checks++;
    if ({f, z, c, dz} !== 7'b0000_1_1_0) begin
      failures++;
      $display("FAIL reset_first_capture got=%b want=%b", {f, z, c, dz}, 7'b0000110);
    end
  endtask

  task automatic test_sweep();
    logic [6:0] exp;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      oc = 3'(i >> 8); a = 4'(i >> 4); b = 4'(i);
      exp = model(3'(i >> 8), 4'(i >> 4), 4'(i));
      @(posedge clk); #1;
      checks++;
      if ({f, z, c, dz} !== exp) begin
        failures++;
        $display("FAIL sweep oc=%0d a=%0d b=%0d got=%b want=%b", oc, a, b, {f, z, c, dz}, exp);
      end
    end
  endtask

  task automatic test_edges();
    vecs = '{
      '{3'd0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0},
      '{3'd1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b1, 1'b0},
      '{3'd1, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0},
      '{3'd2, 4'b0101, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0},
      '{3'd2, 4'b1000, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0},
      '{3'd3, 4'b1101, 4'b0100, 4'b0011, 1'b0, 1'b0, 1'b0},
      '{3'd3, 4'b0111, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1},
      '{3'd4, 4'b1010, 4'b0110, 4'b0101, 1'b0, 1'b0, 1'b0},
      '{3'd5, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0},
      '{3'd6, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0},
      '{3'd7, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      oc = vecs[i].oc; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      checks++;
      if ({f, z, c, dz} !== {vecs[i].f, vecs[i].z, vecs[i].c, vecs[i].dz}) begin
        failures++;
        $display("FAIL edge%0d oc=%0d a=%b b=%b got=%b want=%b", i, oc, a, b, {f, z, c, dz},
                 {vecs[i].f, vecs[i].z, vecs[i].c, vecs[i].dz});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ro;
    logic [3:0] ra, rb;
    logic [6:0] exp;
    for (int i = 0; i < 400; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      @(negedge clk);
      oc = ro; a = ra; b = rb;
      exp = model(ro, ra, rb);
      @(posedge clk); #1;
      checks++;
      if ({f, z, c, dz} !== exp) begin
        failures++;
        $display("FAIL random oc=%0d a=%0d b=%0d got=%b want=%b", ro, ra, rb, {f, z, c, dz}, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sweep();
    test_edges();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
